imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 34 +++
 rtl/imem_rsp_fifo.sv | 61 ++++++
 rtl/imem_responder.sv | 109 ++++++++++
 tb/tb_imem_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder: ROM image,
// response entry layout and legal parameter bounds.
package imem_pkg;

    localparam int IMEM_MAX_WORDS = 1024;
    localparam int IMEM_IDX_W     = 10;

    localparam int LATENCY_MIN    = 1;
    localparam int LATENCY_MAX    = 4;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 8;

    typedef logic [IMEM_MAX_WORDS-1:0][31:0] imem_rom_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] addr;
        logic        err;
    } imem_rsp_t;

    localparam int RSP_W = $bits(imem_rsp_t);

    // Odd multiplier keeps every word distinct, so a wrong index never aliases.
    function automatic imem_rom_t gen_init();
        imem_rom_t rom;
        for (int i = 0; i < IMEM_MAX_WORDS; i++) begin
            rom[i[IMEM_IDX_W-1:0]] = 32'h1300_0000 ^ (32'(i) * 32'h9E37_79B9);
        end
        return rom;
    endfunction

    localparam imem_rom_t IMEM_INIT = gen_init();

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO with a single-edge flush; head output reads as zero
// whenever the FIFO is empty.
module imem_rsp_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && valid;
    assign head    = valid ? mem[rd_ptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction ROM responder for the fetch stage. Optional address
// error checking is enabled by defining IMEM_ERR_CHECK_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [63:0] rsp_addr,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX ||
        FIFO_DEPTH < FIFO_DEPTH_MIN || FIFO_DEPTH > FIFO_DEPTH_MAX ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DEPTH_WORDS < 16 || DEPTH_WORDS > IMEM_MAX_WORDS ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_param_check
        $error("imem_responder: parameter out of range");
    end

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; flush overrides both channels on that edge (nothing transfers).
    logic            accept;
    logic            pop;
    logic [CW-1:0]   outstanding;
    logic [AW-1:0]   rd_idx;
    imem_rsp_t       rd_ent;
    logic [LATENCY-1:0] stg_valid;
    imem_rsp_t       stg_ent [LATENCY];
    imem_rsp_t       head;

    // Outstanding covers pipeline plus FIFO, so the FIFO can never overflow.
    assign req_ready = reset && !flush && (outstanding < CW'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready && !flush;
    assign rd_idx    = req_addr[AW+1:2];

    always_comb begin
        rd_ent.addr = req_addr;
`ifdef IMEM_ERR_CHECK_EN
        rd_ent.err   = (req_addr[1:0] != 2'b00) || (req_addr[63:AW+2] != '0);
        rd_ent.instr = rd_ent.err ? 32'h0 : IMEM_INIT[IMEM_IDX_W'(rd_idx)];
`else
        rd_ent.err   = 1'b0;
        rd_ent.instr = IMEM_INIT[IMEM_IDX_W'(rd_idx)];
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            outstanding <= '0;
        end else if (accept && !pop) begin
            outstanding <= outstanding + CW'(1);
        end else if (pop && !accept) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    // Stage 0 holds the ROM read result; the last stage feeds the FIFO.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            stg_valid <= '0;
        end else begin
            stg_valid[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stg_ent[0] <= rd_ent;
        for (int i = 1; i < LATENCY; i++) begin
            stg_ent[i] <= stg_ent[i-1];
        end
    end

    imem_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (stg_valid[LATENCY-1]),
        .push_data (stg_ent[LATENCY-1]),
        .pop       (pop),
        .valid     (rsp_valid),
        .head      (head)
    );

    assign rsp_instr = head.instr;
    assign rsp_addr  = head.addr;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: directed scenarios plus a random phase,
// checked against a queue-based model of accepted-but-unconsumed requests.
module tb_imem_responder;
    import imem_pkg::*;

    localparam int DEPTH_WORDS = 64;
    localparam int LATENCY     = 2;
    localparam int FIFO_DEPTH  = 2;
    localparam int W           = RSP_W;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [63:0] rsp_addr;
    logic        rsp_err;

    imem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .flush     (flush),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_addr  (rsp_addr),
        .rsp_err   (rsp_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q [$];
    int          acc_q [$];
    int          acc_count = 0;
    int          pop_count = 0;
    logic        seen_rsp = 1'b0;
    logic        model_ready = 1'b0;
    logic        stall_done = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [63:0] a);
        imem_rsp_t r;
        logic [IMEM_IDX_W-1:0] idx;
        idx     = IMEM_IDX_W'((a >> 2) % 64'(DEPTH_WORDS));
        r.addr  = a;
`ifdef IMEM_ERR_CHECK_EN
        r.err   = ((a % 64'd4) != 64'd0) || (a >= 64'(4 * DEPTH_WORDS));
        r.instr = r.err ? 32'h0 : IMEM_INIT[idx];
`else
        r.err   = 1'b0;
        r.instr = IMEM_INIT[idx];
`endif
        return r;
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 3))
            0: a = 64'($urandom_range(0, DEPTH_WORDS - 1)) << 2;
            1: a = (64'($urandom_range(0, DEPTH_WORDS - 1)) << 2) | 64'($urandom_range(1, 3));
            2: a = {32'($urandom), 32'($urandom)};
            default: a = 64'h1_0000_0000 | (64'($urandom_range(0, DEPTH_WORDS - 1)) << 2);
        endcase
        return a;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor: observes state left by the previous edge ----------------
    initial begin
        logic exp_valid;
        forever begin
            @(posedge clk);
            cyc++;
            #3;
            model_ready = reset && !flush && (exp_q.size() < FIFO_DEPTH);
            check("req_ready", 128'(req_ready), 128'(model_ready));
            exp_valid = (exp_q.size() > 0) && (cyc >= acc_q[0] + LATENCY);
            check("rsp_valid", 128'(rsp_valid), 128'(exp_valid));
            if (rsp_valid && exp_valid) begin
                check("rsp_head", 128'({rsp_instr, rsp_addr, rsp_err}), 128'(exp_q[0]));
            end
            if (!rsp_valid && !seen_rsp) begin
                check("idle_outputs_zero", 128'({rsp_instr, rsp_addr, rsp_err}), 128'(0));
            end
            if (rsp_valid) seen_rsp = 1'b1;
            if (reset && !flush && rsp_valid && rsp_ready && exp_valid) begin
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                pop_count++;
            end
        end
    end

    // ---------------- scoreboard push: effect of the upcoming edge ----------------
    initial begin
        forever begin
            @(posedge clk);
            #4;
            if (!reset || flush) begin
                exp_q.delete();
                acc_q.delete();
                if (!reset) seen_rsp = 1'b0;
            end else if (req_valid && model_ready) begin
                exp_q.push_back(model(req_addr));
                acc_q.push_back(cyc + 1);
                acc_count++;
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [63:0] a);
        int   waited;
        logic done;
        waited    = 0;
        done      = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!done && waited < 60) begin
            #3;
            done = req_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout addr %h: got no accept, required accept within 60 cycles", a);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int wait_cnt;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 64'd0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;

        // Sequential fetch of the first three words.
        issue(64'd0);
        issue(64'd4);
        issue(64'd8);
        tick(6);

        // Backpressure: only FIFO_DEPTH requests may be outstanding.
        rsp_ready  = 1'b0;
        base       = acc_count;
        stall_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) issue(64'h10 + 64'(4 * i));
                stall_done = 1'b1;
            end
        join_none
        tick(8);
        check("stall_accept_count", 128'(acc_count - base), 128'(FIFO_DEPTH));
        rsp_ready = 1'b1;
        wait_cnt  = 0;
        while (!stall_done && wait_cnt < 80) begin
            tick(1);
            wait_cnt++;
        end
        check("stall_drain_done", 128'(stall_done), 128'(1));
        tick(6);
        check("stall_total_accepts", 128'(acc_count - base), 128'(4));

        // Flush on the cycle 8 would be accepted; only the later request responds.
        base = pop_count;
        issue(64'd0);
        issue(64'd4);
        req_valid = 1'b1;
        req_addr  = 64'd8;
        flush     = 1'b1;
        tick(1);
        flush     = 1'b0;
        req_valid = 1'b0;
        issue(64'd457515);
        tick(6);
        check("flush_response_count", 128'(pop_count - base), 128'(1));

        // Boundary addresses: one past the end, and misaligned.
        issue(64'(4 * DEPTH_WORDS));
        issue(64'd6);
        issue(64'(4 * DEPTH_WORDS - 4));
        tick(8);

        // Reset with two requests in flight: nothing may come out.
        base = pop_count;
        issue(64'h20);
        issue(64'h24);
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        check("reset_no_response", 128'(pop_count - base), 128'(0));
        issue(64'h28);
        tick(6);
        check("post_reset_response", 128'(pop_count - base), 128'(1));

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        tick(12);
        check("final_drained", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
